btn_event_scheduler: RTL and testbench

- Turns N asynchronous push-button inputs into one stream of timestamp-free button events (PRESS, LONG, REPEAT, RELEASE).
- Each button gets its own synchroniser, edge detector and hold timer.
- Events wait in a one-deep pending slot per button. A round-robin arbiter shares a single valid/ready event port between all buttons.
- Sits between the board buttons and the menu/game FSMs, which consume one event per handshake.

---
 rtl/btn_evt_pkg.sv | 16 +
 rtl/btn_evt_channel.sv | 105 ++++++++++
 rtl/btn_event_scheduler.sv | 101 ++++++++++
 tb/tb_btn_event_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// Shared event-kind codes and per-button state encodings for the button
// event scheduler.
package btn_evt_pkg;

  localparam logic [1:0] EVT_PRESS   = 2'd0;
  localparam logic [1:0] EVT_LONG    = 2'd1;
  localparam logic [1:0] EVT_REPEAT  = 2'd2;
  localparam logic [1:0] EVT_RELEASE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_HELD    = 2'd2
  } btn_state_t;

endpackage

// File: rtl/btn_evt_channel.sv
// One button: three-flop synchroniser, edge detect, press/hold FSM with hold
// counter, and a one-deep pending event slot.
module btn_evt_channel
  import btn_evt_pkg::*;
#(
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic       clk_4,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       grant,
  input  logic       clr,
  output logic       pend_valid,
  output logic [1:0] pend_kind,
  output logic       drop
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  =
    CNT_W'((REPEAT_CYCLES == 0) ? 0 : REPEAT_CYCLES - 1);

  logic             s1, s2, s3;
  logic             rise, fall;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             post;
  logic [1:0]       post_kind;
  logic             counting;
  logic             take;
  logic             accept;
  logic             overwrite;

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // Event decode; a fall always wins over a counter expiry in the same cycle.
  always_comb begin
    post      = 1'b0;
    post_kind = EVT_PRESS;
    if (fall) begin
      post      = 1'b1;
      post_kind = EVT_RELEASE;
    end else begin
      case (state)
        ST_IDLE: if (rise) begin
          post      = 1'b1;
          post_kind = EVT_PRESS;
        end
        ST_PRESSED: if (s2 && cnt == HOLD_LAST) begin
          post      = 1'b1;
          post_kind = EVT_LONG;
        end
        ST_HELD: if (s2 && REPEAT_CYCLES != 0 && cnt == REP_LAST) begin
          post      = 1'b1;
          post_kind = EVT_REPEAT;
        end
        default: ;
      endcase
    end
  end

  assign counting  = s2 & ((state == ST_PRESSED) |
                           ((state == ST_HELD) & (REPEAT_CYCLES != 0)));
  assign take      = grant & clr;
  assign accept    = post & (~pend_valid | take);
  // A pending REPEAT is stale once the button lets go, so RELEASE replaces it.
  assign overwrite = post & pend_valid & ~take &
                     (post_kind == EVT_RELEASE) & (pend_kind == EVT_REPEAT);
  assign drop      = post & ~accept & ~overwrite;

  always_ff @(posedge clk_4 or negedge rst_n) begin
    if (!rst_n) begin
      s1         <= 1'b0;
      s2         <= 1'b0;
      s3         <= 1'b0;
      state      <= ST_IDLE;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_kind  <= EVT_PRESS;
    end else begin
      s1 <= btn;
      s2 <= s1;
      s3 <= s2;
      if (post) begin
        cnt <= '0;
        case (post_kind)
          EVT_PRESS:   state <= ST_PRESSED;
          EVT_RELEASE: state <= ST_IDLE;
          default:     state <= ST_HELD;
        endcase
      end else if (counting) begin
        cnt <= cnt + 1'b1;
      end
      if (accept || overwrite) begin
        pend_valid <= 1'b1;
        pend_kind  <= post_kind;
      end else if (take) begin
        pend_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// N push buttons merged into one valid/ready event stream through a
// round-robin arbiter and a single output register.
module btn_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int N_BTN         = 5,
  parameter int HOLD_CYCLES   = 8,
  parameter int REPEAT_CYCLES = 2,
  parameter int CNT_W         = 4
) (
  input  logic             clk_4,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [2:0]       evt_id,
  output logic [1:0]       evt_kind,
  output logic [N_BTN-1:0] pending,
  output logic             overflow,
  input  logic             clr_overflow
);

  logic [N_BTN-1:0] pend_v;
  logic [N_BTN-1:0] drop_v;
  logic [N_BTN-1:0] grant_v;
  logic [1:0]       pend_k [N_BTN];
  logic [2:0]       rr;
  logic             load;
  logic             any;
  logic [2:0]       gidx;
  logic [1:0]       gkind;
  logic [3:0]       cand;

  // Valid/ready: an event transfers on a rising edge with evt_valid and
  // evt_ready both high; while stalled, evt_id/evt_kind hold.
  assign load    = ~evt_valid | evt_ready;
  assign pending = pend_v;

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    btn_evt_channel #(
      .HOLD_CYCLES  (HOLD_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) u_ch (
      .clk_4     (clk_4),
      .rst_n     (rst_n),
      .btn       (btn_in[i]),
      .grant     (grant_v[i]),
      .clr       (load),
      .pend_valid(pend_v[i]),
      .pend_kind (pend_k[i]),
      .drop      (drop_v[i])
    );
  end

  // Cyclic search starting at rr; the first pending slot found wins.
  always_comb begin
    any   = 1'b0;
    gidx  = 3'd0;
    gkind = EVT_PRESS;
    cand  = 4'd0;
    for (int k = 0; k < N_BTN; k++) begin
      cand = 4'(rr) + 4'(k);
      if (cand >= 4'(N_BTN)) cand = cand - 4'(N_BTN);
      if (!any && pend_v[cand[2:0]]) begin
        any   = 1'b1;
        gidx  = cand[2:0];
        gkind = pend_k[cand[2:0]];
      end
    end
  end

  always_comb begin
    grant_v = '0;
    for (int i = 0; i < N_BTN; i++) grant_v[i] = any && (gidx == 3'(i));
  end

  always_ff @(posedge clk_4 or negedge rst_n) begin
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_id    <= 3'd0;
      evt_kind  <= EVT_PRESS;
      rr        <= 3'd0;
      overflow  <= 1'b0;
    end else begin
      if (load) begin
        if (any) begin
          evt_valid <= 1'b1;
          evt_id    <= gidx;
          evt_kind  <= gkind;
          rr        <= (gidx == 3'(N_BTN - 1)) ? 3'd0 : gidx + 3'd1;
        end else begin
          evt_valid <= 1'b0;
        end
      end
      if (|drop_v)           overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Bench for btn_event_scheduler: vector table, hand sequences for the
// multi-cycle corners, and random stimulus against an event-level model.
module tb_btn_event_scheduler;

  localparam int N    = 5;
  localparam int HOLD = 8;
  localparam int REP  = 2;

  logic         clk_4 = 1'b0;
  logic         rst_n;
  logic [N-1:0] btn_in;
  logic         evt_valid;
  logic         evt_ready;
  logic [2:0]   evt_id;
  logic [1:0]   evt_kind;
  logic [N-1:0] pending;
  logic         overflow;
  logic         clr_overflow;

  btn_event_scheduler dut (
    .clk_4       (clk_4),
    .rst_n       (rst_n),
    .btn_in      (btn_in),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_kind    (evt_kind),
    .pending     (pending),
    .overflow    (overflow),
    .clr_overflow(clr_overflow)
  );

  // clock / reset
  always #5 clk_4 = ~clk_4;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // handshake log and expected-event queue, entries are {id, kind}
  logic [4:0] exp_q[$];
  logic [4:0] got_q[$];
  int         got_t[$];

  // reference model: events derived from press duration, slots, arbiter
  logic [N-1:0] m_smp1, m_smp2, m_last;
  int           m_dur [N];
  logic [N-1:0] m_sv;
  int           m_sk  [N];
  int           m_rr;
  logic         m_valid;
  int           m_id, m_kind;
  logic         m_ovf;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_smp1 = '0; m_smp2 = '0; m_last = '0; m_sv = '0;
    for (int i = 0; i < N; i++) begin m_dur[i] = 0; m_sk[i] = 0; end
    m_rr = 0; m_valid = 1'b0; m_id = 0; m_kind = 0; m_ovf = 1'b0;
  endtask

  // Advance the model by one edge using the inputs present before it.
  task automatic model_step();
    int   ev [N];
    int   taken;
    int   idx;
    logic seen, was, set;
    for (int i = 0; i < N; i++) begin
      seen  = m_smp2[i];
      was   = m_last[i];
      ev[i] = -1;
      if (seen && !was) begin
        ev[i] = 0; m_dur[i] = 0;
      end else if (!seen && was) begin
        ev[i] = 3;
      end else if (seen) begin
        m_dur[i]++;
        if (m_dur[i] == HOLD) ev[i] = 1;
        else if (REP != 0 && m_dur[i] > HOLD && (m_dur[i] - HOLD) % REP == 0) ev[i] = 2;
      end
    end
    if (!m_valid || evt_ready) begin
      taken = -1;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (taken < 0 && m_sv[idx]) taken = idx;
      end
      if (taken >= 0) begin
        m_valid = 1'b1; m_id = taken; m_kind = m_sk[taken];
        m_sv[taken] = 1'b0;
        m_rr = (taken + 1) % N;
      end else begin
        m_valid = 1'b0;
      end
    end
    set = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (ev[i] >= 0) begin
        if (!m_sv[i]) begin m_sv[i] = 1'b1; m_sk[i] = ev[i]; end
        else if (ev[i] == 3 && m_sk[i] == 2) m_sk[i] = 3;
        else set = 1'b1;
      end
    end
    if (set) m_ovf = 1'b1;
    else if (clr_overflow) m_ovf = 1'b0;
    m_last = m_smp2; m_smp2 = m_smp1; m_smp1 = btn_in;
  endtask

  task automatic compare_model();
    chk("m_valid", 8'(evt_valid), 8'(m_valid));
    if (m_valid) begin
      chk("m_id", 8'(evt_id), 8'(m_id));
      chk("m_kind", 8'(evt_kind), 8'(m_kind));
    end
    chk("m_pending", 8'(pending), 8'(m_sv));
    chk("m_overflow", 8'(overflow), 8'(m_ovf));
  endtask

  // driver: one clock, logging the handshake that this edge completes
  task automatic cycle();
    if (evt_valid && evt_ready) begin
      got_q.push_back({evt_id, evt_kind});
      got_t.push_back(cyc);
    end
    model_step();
    @(posedge clk_4);
    #1;
    cyc++;
    compare_model();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_4);
    #1;
    chk("rst_valid", 8'(evt_valid), 8'd0);
    chk("rst_id", 8'(evt_id), 8'd0);
    chk("rst_kind", 8'(evt_kind), 8'd0);
    chk("rst_pending", 8'(pending), 8'd0);
    chk("rst_overflow", 8'(overflow), 8'd0);
    @(negedge clk_4);
    rst_n = 1'b1;
  endtask

  task automatic check_log(input string name);
    chk({name, "_count"}, 8'(got_q.size()), 8'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(name, 8'(got_q[i]), 8'(exp_q[i]));
    got_q.delete(); got_t.delete(); exp_q.delete();
  endtask

  typedef struct {
    logic [N-1:0] btn;
    logic         ready;
    logic         ev;
    logic [2:0]   eid;
    logic [1:0]   ek;
    logic [N-1:0] ep;
  } vec_t;

  vec_t tbl[18];

  initial begin
    // buttons 0,1,4 together from rr = 0, then a 3-cycle press of button 2
    tbl[0]  = '{5'b10011, 1, 0, 0, 0, 5'b00000};
    tbl[1]  = '{5'b10011, 1, 0, 0, 0, 5'b00000};
    tbl[2]  = '{5'b10011, 1, 0, 0, 0, 5'b10011};
    tbl[3]  = '{5'b00000, 1, 1, 0, 0, 5'b10010};
    tbl[4]  = '{5'b00000, 1, 1, 1, 0, 5'b10000};
    tbl[5]  = '{5'b00000, 1, 1, 4, 0, 5'b10011};
    tbl[6]  = '{5'b00000, 1, 1, 0, 3, 5'b10010};
    tbl[7]  = '{5'b00000, 1, 1, 1, 3, 5'b10000};
    tbl[8]  = '{5'b00000, 1, 1, 4, 3, 5'b00000};
    tbl[9]  = '{5'b00000, 1, 0, 0, 0, 5'b00000};
    tbl[10] = '{5'b00100, 1, 0, 0, 0, 5'b00000};
    tbl[11] = '{5'b00100, 1, 0, 0, 0, 5'b00000};
    tbl[12] = '{5'b00100, 1, 0, 0, 0, 5'b00100};
    tbl[13] = '{5'b00000, 1, 1, 2, 0, 5'b00000};
    tbl[14] = '{5'b00000, 1, 0, 0, 0, 5'b00000};
    tbl[15] = '{5'b00000, 1, 0, 0, 0, 5'b00100};
    tbl[16] = '{5'b00000, 1, 1, 2, 3, 5'b00000};
    tbl[17] = '{5'b00000, 1, 0, 0, 0, 5'b00000};

    btn_in = '0; evt_ready = 1'b0; clr_overflow = 1'b0;
    do_reset();

    for (int r = 0; r < 18; r++) begin
      btn_in = tbl[r].btn; evt_ready = tbl[r].ready;
      cycle();
      chk("tbl_valid", 8'(evt_valid), 8'(tbl[r].ev));
      if (tbl[r].ev) begin
        chk("tbl_id", 8'(evt_id), 8'(tbl[r].eid));
        chk("tbl_kind", 8'(evt_kind), 8'(tbl[r].ek));
      end
      chk("tbl_pending", 8'(pending), 8'(tbl[r].ep));
    end

    // long hold of button 0: PRESS, LONG, three REPEATs, RELEASE
    got_q.delete(); got_t.delete();
    exp_q = '{5'b00000, 5'b00001, 5'b00010, 5'b00010, 5'b00010, 5'b00011};
    evt_ready = 1'b1;
    for (int c = 0; c < 23; c++) begin
      btn_in = (c < 15) ? 5'b00001 : 5'b00000;
      cycle();
    end
    if (got_t.size() >= 6) begin
      chk("long_gap", 8'(got_t[1] - got_t[0]), 8'(HOLD));
      chk("rep_gap1", 8'(got_t[2] - got_t[1]), 8'(REP));
      chk("rep_gap2", 8'(got_t[3] - got_t[2]), 8'(REP));
    end
    chk("hold_overflow", 8'(overflow), 8'd0);
    check_log("hold_seq");

    // single-cycle glitch on button 4
    exp_q = '{5'b10000, 5'b10011};
    for (int c = 0; c < 9; c++) begin
      btn_in = (c == 0) ? 5'b10000 : 5'b00000;
      cycle();
    end
    check_log("glitch_seq");

    // stalled port: button 3 press, release and re-press overflows its slot
    evt_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      btn_in = (c < 3 || c >= 6) ? 5'b01000 : 5'b00000;
      cycle();
    end
    chk("stall_overflow", 8'(overflow), 8'd1);
    chk("stall_valid", 8'(evt_valid), 8'd1);
    chk("stall_id", 8'(evt_id), 8'd3);
    chk("stall_kind", 8'(evt_kind), 8'd0);
    clr_overflow = 1'b1;
    cycle();
    clr_overflow = 1'b0;
    chk("clr_overflow", 8'(overflow), 8'd0);
    btn_in = '0; evt_ready = 1'b1;
    repeat (12) cycle();

    // pending REPEAT replaced by RELEASE while the port is stalled
    for (int c = 0; c < 15; c++) begin
      btn_in    = (c < 12) ? 5'b00001 : 5'b00000;
      evt_ready = (c <= 11);
      cycle();
    end
    chk("ovw_overflow", 8'(overflow), 8'd0);
    chk("ovw_pending", 8'(pending), 8'b00001);
    evt_ready = 1'b1;
    cycle();
    chk("ovw_valid", 8'(evt_valid), 8'd1);
    chk("ovw_id", 8'(evt_id), 8'd0);
    chk("ovw_kind", 8'(evt_kind), 8'd3);
    repeat (6) cycle();

    // reset while button 1 is held past LONG, then PRESS again after release
    evt_ready = 1'b0; btn_in = 5'b00010;
    repeat (13) cycle();
    chk("pre_rst_valid", 8'(evt_valid), 8'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("async_valid", 8'(evt_valid), 8'd0);
    chk("async_id", 8'(evt_id), 8'd0);
    chk("async_kind", 8'(evt_kind), 8'd0);
    chk("async_pending", 8'(pending), 8'd0);
    chk("async_overflow", 8'(overflow), 8'd0);
    repeat (2) @(posedge clk_4);
    @(negedge clk_4);
    rst_n = 1'b1;
    evt_ready = 1'b1;
    repeat (2) cycle();
    chk("rel_pend2", 8'(pending), 8'd0);
    cycle();
    chk("rel_pend3", 8'(pending), 8'b00010);
    cycle();
    chk("rel_valid", 8'(evt_valid), 8'd1);
    chk("rel_id", 8'(evt_id), 8'd1);
    chk("rel_kind", 8'(evt_kind), 8'd0);
    btn_in = '0;
    repeat (8) cycle();

    // random stimulus against the model
    for (int c = 0; c < 600; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 9) == 0) btn_in[b] = ~btn_in[b];
      evt_ready    = ($urandom_range(0, 3) != 0);
      clr_overflow = ($urandom_range(0, 15) == 0);
      cycle();
    end
    btn_in = '0; evt_ready = 1'b1; clr_overflow = 1'b0;
    repeat (12) cycle();
    chk("final_pending", 8'(pending), 8'd0);
    chk("final_valid", 8'(evt_valid), 8'd0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
